// File: rtl/inv_round_pkg.sv
// inv_round_pkg: shared state type, S-box tables and forward/inverse SPN round functions.
package inv_round_pkg;

    localparam int NIBW = 4;

    localparam logic [NIBW-1:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [NIBW-1:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // GF(2^4) multiply, reduction polynomial x^4+x+1.
    function automatic logic [NIBW-1:0] gf16_mul(input logic [NIBW-1:0] a, input logic [NIBW-1:0] b);
        logic [NIBW-1:0] p;
        logic [NIBW-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < NIBW; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = {x[NIBW-2:0], 1'b0} ^ (x[NIBW-1] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // [[3,2],[2,3]] squares to identity, so one mix serves both directions.
    function automatic logic [15:0] mix_cols(input logic [15:0] s);
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            r[c*2*NIBW +: NIBW] = gf16_mul(4'h3, s[c*2*NIBW +: NIBW])
                                ^ gf16_mul(4'h2, s[c*2*NIBW+NIBW +: NIBW]);
            r[c*2*NIBW+NIBW +: NIBW] = gf16_mul(4'h2, s[c*2*NIBW +: NIBW])
                                     ^ gf16_mul(4'h3, s[c*2*NIBW+NIBW +: NIBW]);
        end
        return r;
    endfunction

    function automatic logic [15:0] swap_n1_n3(input logic [15:0] s);
        return {s[7:4], s[11:8], s[15:12], s[3:0]};
    endfunction

    function automatic logic [15:0] sub_nibbles(input logic [15:0] s, input logic inv);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[i*NIBW +: NIBW] = inv ? INV_SBOX[s[i*NIBW +: NIBW]] : SBOX[s[i*NIBW +: NIBW]];
        return r;
    endfunction

    function automatic logic [15:0] fwd_round(input logic [15:0] d, input logic [15:0] k);
        return mix_cols(swap_n1_n3(sub_nibbles(d ^ k, 1'b0)));
    endfunction

    function automatic logic [15:0] inv_round(input logic [15:0] d, input logic [15:0] k);
        return sub_nibbles(swap_n1_n3(mix_cols(d)), 1'b1) ^ k;
    endfunction

endpackage

// File: rtl/inv_round_comb.sv
// inv_round_comb: one combinational inverse SPN round.
module inv_round_comb
    import inv_round_pkg::*;
(
    input  logic [15:0] data_i,
    input  logic [15:0] key_i,
    output logic [15:0] data_o
);

    assign data_o = inv_round(data_i, key_i);

endmodule

// File: rtl/inv_round_iter.sv
// inv_round_iter: iterative decryptor applying NROUNDS inverse rounds per word from an internal key file.
// Define INV_ROUND_ITER_UNROLL2_EN to apply two rounds per clock (same ports and results, lower latency).
module inv_round_iter
    import inv_round_pkg::*;
#(
    parameter int DATAW   = 16,
    parameter int NROUNDS = 4,
    parameter int KIDXW   = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_we_i,
    input  logic [KIDXW-1:0] key_idx_i,
    input  logic [DATAW-1:0] key_i,
    input  logic             ct_valid_i,
    output logic             ct_ready_o,
    input  logic [DATAW-1:0] ct_i,
    output logic             pt_valid_o,
    input  logic             pt_ready_i,
    output logic [DATAW-1:0] pt_o,
    output logic             busy_o
);

    if (DATAW != 16 || NROUNDS < 1 || NROUNDS > 15) begin : g_bad_cfg
        $error("inv_round_iter: DATAW must be 16 and NROUNDS within 1..15");
    end

    state_t           state_q, state_d;
    logic [DATAW-1:0] data_q, data_d;
    logic [KIDXW-1:0] rnd_q, rnd_d;
    logic [DATAW-1:0] key_q [NROUNDS];
    logic [DATAW-1:0] key_d [NROUNDS];
    logic             ct_ready_q, pt_valid_q, busy_q;
    logic [DATAW-1:0] r1, step;
    logic [KIDXW-1:0] rnd_next;
    logic             last;

    inv_round_comb u_round0 (.data_i(data_q), .key_i(key_q[rnd_q]), .data_o(r1));

`ifdef INV_ROUND_ITER_UNROLL2_EN
    logic [DATAW-1:0] r2;
    logic [KIDXW-1:0] rnd_lo;
    assign rnd_lo = (rnd_q == '0) ? '0 : rnd_q - KIDXW'(1);
    inv_round_comb u_round1 (.data_i(r1), .key_i(key_q[rnd_lo]), .data_o(r2));
    // An odd round count ends on rnd=0, where only the first round applies.
    assign last     = rnd_q <= KIDXW'(1);
    assign step     = (rnd_q == '0) ? r1 : r2;
    assign rnd_next = rnd_q - KIDXW'(1) - KIDXW'(1);
`else
    assign last     = rnd_q == '0;
    assign step     = r1;
    assign rnd_next = rnd_q - KIDXW'(1);
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rnd_d   = rnd_q;
        for (int i = 0; i < NROUNDS; i++)
            key_d[i] = (state_q == IDLE && key_we_i && key_idx_i == KIDXW'(i)) ? key_i : key_q[i];
        if (state_q == IDLE && ct_valid_i) begin
            state_d = RUN;
            data_d  = ct_i;
            rnd_d   = KIDXW'(NROUNDS - 1);
        end else if (state_q == RUN) begin
            data_d  = step;
            rnd_d   = last ? '0 : rnd_next;
            state_d = last ? DONE : RUN;
        end else if (state_q == DONE && pt_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            data_q     <= '0;
            rnd_q      <= '0;
            key_q      <= '{default: '0};
            ct_ready_q <= 1'b1;
            pt_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rnd_q      <= rnd_d;
            key_q      <= key_d;
            ct_ready_q <= state_d == IDLE;
            pt_valid_q <= state_d == DONE;
            busy_q     <= state_d != IDLE;
        end
    end

    assign ct_ready_o = ct_ready_q;
    assign pt_valid_o = pt_valid_q;
    assign busy_o     = busy_q;
    assign pt_o       = data_q;

endmodule

// File: tb/tb_inv_round_iter.sv
// tb_inv_round_iter: directed checks of inv_round_iter built with NROUNDS = 4, 1 and 3.
module tb_inv_round_iter;
    import inv_round_pkg::*;

    localparam int NR [3] = '{4, 1, 3};
    localparam logic [15:0] VC [6] = '{16'h0000, 16'h0001, 16'h0100, 16'h00F0, 16'h0000, 16'h0001};
    localparam logic [15:0] VK [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    localparam logic [15:0] VE [6] = '{16'h5555, 16'hF558, 16'h58F5, 16'hF557, 16'hAAAA, 16'h0AA7};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_we   [3];
    logic [3:0]  key_idx  [3];
    logic [15:0] key      [3];
    logic        ct_valid [3];
    logic        ct_ready [3];
    logic [15:0] ct       [3];
    logic        pt_valid [3];
    logic        pt_ready [3];
    logic [15:0] pt       [3];
    logic        busy     [3];
    logic [15:0] k4 [4];
    logic [15:0] k3 [4];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KW = (NR[g] > 1) ? $clog2(NR[g]) : 1;
        inv_round_iter #(.NROUNDS(NR[g])) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .key_we_i(key_we[g]), .key_idx_i(key_idx[g][KW-1:0]), .key_i(key[g]),
            .ct_valid_i(ct_valid[g]), .ct_ready_o(ct_ready[g]), .ct_i(ct[g]),
            .pt_valid_o(pt_valid[g]), .pt_ready_i(pt_ready[g]), .pt_o(pt[g]),
            .busy_o(busy[g])
        );
    end

    function automatic int lat_of(input int n);
`ifdef INV_ROUND_ITER_UNROLL2_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    // Encryption applies K[0] first, so decryption must finish with K[0].
    function automatic logic [15:0] encrypt(input logic [15:0] p, input logic [15:0] ks [4], input int n);
        logic [15:0] x;
        x = p;
        for (int r = 0; r < n; r++) x = fwd_round(x, ks[r]);
        return x;
    endfunction

    task automatic write_key(input int d, input int idx, input logic [15:0] k);
        @(negedge clk);
        key_we[d] = 1'b1; key_idx[d] = 4'(idx); key[d] = k;
        @(negedge clk);
        key_we[d] = 1'b0;
    endtask

    // mode 1: key write in the acceptance cycle; mode 2: key write in the first RUN cycle.
    task automatic run_word(input int d, input logic [15:0] c, input int mode, input int idx,
                            input logic [15:0] k, output logic [15:0] res, output int lat);
        @(negedge clk);
        ct[d] = c; ct_valid[d] = 1'b1; pt_ready[d] = 1'b1;
        key_we[d] = (mode == 1); key_idx[d] = 4'(idx); key[d] = k;
        @(negedge clk);
        ct_valid[d] = 1'b0;
        key_we[d] = (mode == 2);
        lat = 0;
        while (pt_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            key_we[d] = 1'b0;
            lat++;
        end
        key_we[d] = 1'b0;
        res = pt[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({ct_ready[d], pt_valid[d], busy[d], pt[d]} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                n_bad++;
                $display("FAIL reset[%0d]: ready/valid/busy/pt got %b%b%b/%h want 100/0000",
                         d, ct_ready[d], pt_valid[d], busy[d], pt[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            write_key(1, 0, VK[i]);
            run_word(1, VC[i], 0, 0, 16'h0, res, lat);
            n_cmp++;
            if (res !== VE[i]) begin
                n_bad++;
                $display("FAIL vec_data[%0d]: got %h want %h", i, res, VE[i]);
            end
            n_cmp++;
            if (lat !== lat_of(1)) begin
                n_bad++;
                $display("FAIL vec_latency[%0d]: got %0d want %0d", i, lat, lat_of(1));
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [15:0] p, res;
        int lat;
        k4 = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h5A5A};
        for (int r = 0; r < 4; r++) write_key(0, r, k4[r]);
        for (int i = 0; i < 1000; i++) begin
            p = 16'($urandom);
            run_word(0, encrypt(p, k4, 4), 0, 0, 16'h0, res, lat);
            n_cmp++;
            if (res !== p) begin
                n_bad++;
                $display("FAIL rt_data[%0d]: got %h want %h", i, res, p);
            end
            n_cmp++;
            if (lat !== lat_of(4)) begin
                n_bad++;
                $display("FAIL rt_latency[%0d]: got %0d want %0d", i, lat, lat_of(4));
            end
        end
    endtask

    task automatic test_odd();
        logic [15:0] p, res;
        int lat;
        k3 = '{16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h0000};
        for (int r = 0; r < 3; r++) write_key(2, r, k3[r]);
        for (int i = 0; i < 20; i++) begin
            p = 16'($urandom);
            run_word(2, encrypt(p, k3, 3), 0, 0, 16'h0, res, lat);
            n_cmp++;
            if (res !== p || lat !== lat_of(3)) begin
                n_bad++;
                $display("FAIL odd[%0d]: got %h lat %0d want %h lat %0d", i, res, lat, p, lat_of(3));
            end
        end
    endtask

    task automatic test_key_writes();
        logic [15:0] res;
        int lat;
        run_word(0, encrypt(16'hBEEF, k4, 4), 2, 0, 16'hFFFF, res, lat);
        n_cmp++;
        if (res !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL kw_run_drop: got %h want beef", res);
        end
        run_word(0, encrypt(16'h1357, k4, 4), 0, 0, 16'h0, res, lat);
        n_cmp++;
        if (res !== 16'h1357) begin
            n_bad++;
            $display("FAIL kw_run_drop_after: got %h want 1357", res);
        end
        write_key(2, 3, 16'hFFFF);
        run_word(2, encrypt(16'h2468, k3, 3), 0, 0, 16'h0, res, lat);
        n_cmp++;
        if (res !== 16'h2468) begin
            n_bad++;
            $display("FAIL kw_idx_drop: got %h want 2468", res);
        end
        k4[0] = 16'h7777;
        run_word(0, encrypt(16'hA5C3, k4, 4), 1, 0, 16'h7777, res, lat);
        n_cmp++;
        if (res !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL kw_same_cycle: got %h want a5c3", res);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int lat;
        @(negedge clk);
        ct[0] = encrypt(16'hC0DE, k4, 4); ct_valid[0] = 1'b1; pt_ready[0] = 1'b0;
        @(negedge clk);
        ct_valid[0] = 1'b0;
        lat = 0;
        while (pt_valid[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (pt[0] !== 16'hC0DE || lat !== lat_of(4)) begin
            n_bad++;
            $display("FAIL bp_first: got %h lat %0d want c0de lat %0d", pt[0], lat, lat_of(4));
        end
        ct[0] = 16'h1111; ct_valid[0] = 1'b1;
        key_we[0] = 1'b1; key_idx[0] = 4'd1; key[0] = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({pt_valid[0], ct_ready[0], busy[0], pt[0]} !== {1'b1, 1'b0, 1'b1, 16'hC0DE}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: valid/ready/busy/pt got %b%b%b/%h want 101/c0de",
                         i, pt_valid[0], ct_ready[0], busy[0], pt[0]);
            end
        end
        ct_valid[0] = 1'b0; key_we[0] = 1'b0; pt_ready[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({pt_valid[0], ct_ready[0], busy[0]} !== 3'b010) begin
            n_bad++;
            $display("FAIL bp_release: valid/ready/busy got %b%b%b want 010", pt_valid[0], ct_ready[0], busy[0]);
        end
        run_word(0, encrypt(16'h0F0F, k4, 4), 0, 0, 16'h0, res, lat);
        n_cmp++;
        if (res !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL bp_done_write_drop: got %h want 0f0f", res);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] res;
        logic [15:0] kz [4];
        logic seen;
        int lat;
        kz = '{default: 16'h0000};
        @(negedge clk);
        ct[0] = 16'h1234; ct_valid[0] = 1'b1; pt_ready[0] = 1'b1;
        @(negedge clk);
        ct_valid[0] = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_busy: got %b want 1", busy[0]);
        end
        rst_n = 1'b0;
        seen = pt_valid[0];
        @(negedge clk);
        n_cmp++;
        if ({ct_ready[0], pt_valid[0], busy[0], pt[0]} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL mr_in_reset: ready/valid/busy/pt got %b%b%b/%h want 100/0000",
                     ct_ready[0], pt_valid[0], busy[0], pt[0]);
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen = seen | (pt_valid[0] === 1'b1);
        end
        n_cmp++;
        if (seen !== 1'b0 || ct_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_no_output: valid_seen %b ready %b want 0 1", seen, ct_ready[0]);
        end
        run_word(1, 16'h0000, 0, 0, 16'h0, res, lat);
        n_cmp++;
        if (res !== 16'h5555) begin
            n_bad++;
            $display("FAIL mr_keys_cleared_n1: got %h want 5555", res);
        end
        run_word(0, encrypt(16'h4242, kz, 4), 0, 0, 16'h0, res, lat);
        n_cmp++;
        if (res !== 16'h4242) begin
            n_bad++;
            $display("FAIL mr_keys_cleared_n4: got %h want 4242", res);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            key_we[d] = 1'b0; key_idx[d] = 4'd0; key[d] = 16'h0;
            ct_valid[d] = 1'b0; ct[d] = 16'h0; pt_ready[d] = 1'b1;
        end
        test_reset();
        test_vectors();
        test_roundtrip();
        test_odd();
        test_key_writes();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
